// File: rtl/mips_cpu_hilo_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package mips_cpu_hilo_pkg;

    localparam int HILO_WIDTH = 32;

    // Operation codes; 3'd6 and 3'd7 are undefined and act as no-ops.
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_DIVIDE = 1'b1
    } state_e;

endpackage

// File: rtl/mips_cpu_hilo_if.sv
// Request/result bundle of the HI/LO unit. The op field is kept as raw bits
// so that undefined codes can be carried.
interface mips_cpu_hilo_if #(
    parameter int WIDTH = mips_cpu_hilo_pkg::HILO_WIDTH
);
    logic             op_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             busy;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             div_by_zero;

    modport master (
        output op_valid, op, rs_val, rt_val,
        input  busy, hi_out, lo_out, div_by_zero
    );

    modport slave (
        input  op_valid, op, rs_val, rt_val,
        output busy, hi_out, lo_out, div_by_zero
    );
endinterface

// File: rtl/mips_cpu_hilo_divider.sv
// Iterative restoring unsigned divider: one quotient bit per clock.
// start loads the operands; done is high during the last step and the
// quotient/remainder outputs carry that step's result combinationally, so
// the parent can commit them on the same edge.
module mips_cpu_hilo_divider
    import mips_cpu_hilo_pkg::*;
#(
    parameter int WIDTH = HILO_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH);

    logic             active_q, active_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] rem_step, quo_step;

    // One restoring step: shift in the next dividend bit, trial-subtract.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        if (!diff[WIDTH]) begin
            rem_step = diff[WIDTH-1:0];
            quo_step = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_step = shifted[WIDTH-1:0];
            quo_step = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    assign done      = active_q && (cnt_q == CW'(WIDTH - 1));
    assign quotient  = quo_step;
    assign remainder = rem_step;

    // Load on start, otherwise iterate while active.
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
            rem_d    = '0;
            quo_d    = dividend;
            dvs_d    = divisor;
        end else if (active_q) begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q + CW'(1);
            if (done) active_d = 1'b0;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
        end
    end
endmodule

// File: rtl/mips_cpu_hilo_unit.sv
// MIPS HI/LO unit: single-cycle MULT/MULTU/MTHI/MTLO and, when the macro
// MIPS_CPU_HILO_DIV_EN is defined, a WIDTH-cycle DIV/DIVU. Without the macro
// DIV/DIVU are no-ops and busy/div_by_zero are constant 0.
module mips_cpu_hilo_unit
    import mips_cpu_hilo_pkg::*;
#(
    parameter int WIDTH = HILO_WIDTH
) (
    input  logic            clk,
    input  logic            reset,
    mips_cpu_hilo_if.slave  bus
);
    op_e                op_s;
    logic               accept;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] prod_u, prod_s;

    assign op_s   = op_e'(bus.op);
    assign accept = bus.op_valid && !bus.busy;

    // Full-width products; sign extension to 2*WIDTH gives the signed result.
    assign prod_u = {{WIDTH{1'b0}}, bus.rs_val} * {{WIDTH{1'b0}}, bus.rt_val};
    assign prod_s = {{WIDTH{bus.rs_val[WIDTH-1]}}, bus.rs_val}
                  * {{WIDTH{bus.rt_val[WIDTH-1]}}, bus.rt_val};

    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;

`ifdef MIPS_CPU_HILO_DIV_EN
    state_e           state_q, state_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d, dbz_q, dbz_d;
    logic             div_start, div_done, div_signed;
    logic [WIDTH-1:0] dvd_abs, dvs_abs, div_quo, div_rem;

    assign bus.busy        = (state_q == ST_DIVIDE);
    assign bus.div_by_zero = dbz_q;

    // Signed divide runs on magnitudes; signs are restored at the final write.
    assign div_signed = (op_s == OP_DIV);
    assign dvd_abs = (div_signed && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
    assign dvs_abs = (div_signed && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;

    mips_cpu_hilo_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (dvd_abs),
        .divisor   (dvs_abs),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );
`else
    assign bus.busy        = 1'b0;
    assign bus.div_by_zero = 1'b0;
`endif

    // Next HI/LO and control state from the accepted request or divide completion.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
`ifdef MIPS_CPU_HILO_DIV_EN
        state_d   = state_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        dbz_d     = 1'b0;
        div_start = 1'b0;
`endif
        if (accept) begin
            case (op_s)
                OP_MULT:  {hi_d, lo_d} = prod_s;
                OP_MULTU: {hi_d, lo_d} = prod_u;
                OP_MTHI:  hi_d = bus.rs_val;
                OP_MTLO:  lo_d = bus.rs_val;
`ifdef MIPS_CPU_HILO_DIV_EN
                OP_DIV, OP_DIVU: begin
                    if (bus.rt_val == '0) begin
                        hi_d  = bus.rs_val;
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else begin
                        div_start = 1'b1;
                        state_d   = ST_DIVIDE;
                        qneg_d    = div_signed && (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
                        rneg_d    = div_signed && bus.rs_val[WIDTH-1];
                    end
                end
`endif
                default: ;
            endcase
        end
`ifdef MIPS_CPU_HILO_DIV_EN
        if (div_done) begin
            lo_d    = qneg_q ? -div_quo : div_quo;
            hi_d    = rneg_q ? -div_rem : div_rem;
            state_d = ST_IDLE;
        end
`endif
    end

    // HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

`ifdef MIPS_CPU_HILO_DIV_EN
    // Divide control state, sign flags and the divide-by-zero pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dbz_q   <= dbz_d;
        end
    end
`endif
endmodule

// File: tb/tb_mips_cpu_hilo_unit.sv
// Scoreboard bench for mips_cpu_hilo_unit (WIDTH=32). The driver predicts the
// visible HI/LO/busy/div_by_zero for specific cycles and queues them; the
// monitor compares every queued expectation on the falling edge of its cycle.
module tb_mips_cpu_hilo_unit;
    import mips_cpu_hilo_pkg::*;

    localparam int W = 32;
`ifdef MIPS_CPU_HILO_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mips_cpu_hilo_if #(.WIDTH(W)) bus ();

    mips_cpu_hilo_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        busy;
        logic        dbz;
        string       name;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    // Reference state: visible HI/LO, a pending divide result and its commit edge.
    logic [31:0] hi_m = '0, lo_m = '0, pend_hi = '0, pend_lo = '0;
    bit          pend = 1'b0;
    int          pend_edge = 0;
    int          free_edge = 0;

    task automatic push(input int due, input logic [31:0] h, input logic [31:0] l,
                        input logic b, input logic d, input string name);
        exp_t x;
        x.due = due; x.hi = h; x.lo = l; x.busy = b; x.dbz = d; x.name = name;
        sb.push_back(x);
    endtask

    // Monitor: compare every expectation due this cycle; late ones are failures.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due <= cyc) begin
                    tests++;
                    if (sb[i].due < cyc || bus.hi_out !== sb[i].hi || bus.lo_out !== sb[i].lo ||
                        bus.busy !== sb[i].busy || bus.div_by_zero !== sb[i].dbz) begin
                        fails++;
                        $display("FAIL %s cyc=%0d due=%0d: got hi=%h lo=%h busy=%b dbz=%b, want hi=%h lo=%h busy=%b dbz=%b",
                                 sb[i].name, cyc, sb[i].due, bus.hi_out, bus.lo_out, bus.busy,
                                 bus.div_by_zero, sb[i].hi, sb[i].lo, sb[i].busy, sb[i].dbz);
                    end else begin
                        $display("[TB] ok   %s cyc=%0d hi=%h lo=%h busy=%b dbz=%b",
                                 sb[i].name, cyc, bus.hi_out, bus.lo_out, bus.busy, bus.div_by_zero);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_free();
        while (cyc + 1 < free_edge) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one request for one edge and record what the model expects.
    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input string name);
        int          e;
        bit          dbz;
        logic [63:0] p;
        longint      a, b, q, r;
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.rs_val   = rs;
        bus.rt_val   = rt;
        e   = cyc + 1;
        dbz = 1'b0;
        if (pend && e >= pend_edge) begin
            hi_m = pend_hi;
            lo_m = pend_lo;
            pend = 1'b0;
        end
        if (e < free_edge) begin
            push(e, hi_m, lo_m, pend, 1'b0, {name, " ignored"});
        end else begin
            case (op)
                OP_MULTU: begin
                    p = 64'(rs) * 64'(rt);
                    {hi_m, lo_m} = p;
                end
                OP_MULT: begin
                    a = longint'($signed(rs));
                    b = longint'($signed(rt));
                    p = 64'(a * b);
                    {hi_m, lo_m} = p;
                end
                OP_MTHI: hi_m = rs;
                OP_MTLO: lo_m = rs;
                OP_DIV, OP_DIVU: begin
                    if (DIV_EN) begin
                        if (rt == 32'd0) begin
                            hi_m = rs;
                            lo_m = 32'hFFFF_FFFF;
                            dbz  = 1'b1;
                        end else begin
                            if (op == OP_DIV) begin
                                a = longint'($signed(rs));
                                b = longint'($signed(rt));
                            end else begin
                                a = longint'({32'd0, rs});
                                b = longint'({32'd0, rt});
                            end
                            q = a / b;
                            r = a % b;
                            pend_lo   = q[31:0];
                            pend_hi   = r[31:0];
                            pend      = 1'b1;
                            pend_edge = e + W;
                            free_edge = e + W + 1;
                        end
                    end
                end
                default: ;
            endcase
            if (pend && pend_edge == e + W) begin
                push(e,         hi_m,    lo_m,    1'b1, 1'b0, {name, " start"});
                push(e + W - 1, hi_m,    lo_m,    1'b1, 1'b0, {name, " last busy"});
                push(e + W,     pend_hi, pend_lo, 1'b0, 1'b0, {name, " result"});
            end else begin
                push(e, hi_m, lo_m, 1'b0, dbz, name);
                if (dbz) push(e + 1, hi_m, lo_m, 1'b0, 1'b0, {name, " pulse end"});
            end
        end
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        if (dbz) idle(1);
    endtask

    // Asynchronous reset in mid-cycle; outputs must clear before the next edge.
    task automatic async_reset(input string name);
        #1;
        reset = 1'b1;
        #1;
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].due >= cyc) sb.delete(i);
        hi_m = '0; lo_m = '0; pend = 1'b0; free_edge = 0;
        push(cyc, '0, '0, 1'b0, 1'b0, name);
        push(cyc + 1, '0, '0, 1'b0, 1'b0, {name, " held"});
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [31:0] rs_r, rt_r;
    logic [2:0]  op_r;

    initial begin
        bus.op_valid = 1'b0;
        bus.op       = 3'd0;
        bus.rs_val   = '0;
        bus.rt_val   = '0;
        @(posedge clk);
        #1;
        tests++;
        if (bus.hi_out !== '0 || bus.lo_out !== '0 || bus.busy !== 1'b0 || bus.div_by_zero !== 1'b0) begin
            fails++;
            $display("FAIL reset state direct: hi=%h lo=%h busy=%b dbz=%b",
                     bus.hi_out, bus.lo_out, bus.busy, bus.div_by_zero);
        end else begin
            $display("[TB] ok   reset state direct hi=%h lo=%h busy=%b dbz=%b",
                     bus.hi_out, bus.lo_out, bus.busy, bus.div_by_zero);
        end
        push(cyc, '0, '0, 1'b0, 1'b0, "reset state");
        @(posedge clk);
        #1;
        reset = 1'b0;

        issue(OP_MTHI,  32'hDEAD_BEEF, 32'h0, "MTHI");
        issue(OP_MTLO,  32'h1234_5678, 32'h0, "MTLO");
        issue(OP_MULT,  32'hFFFF_FFFF, 32'h2, "MULT -1*2");
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'h2, "MULTU ffffffff*2");
        issue(3'd6,     32'h1111_1111, 32'h2, "undef op 6");
        issue(3'd7,     32'h2222_2222, 32'h3, "undef op 7");
        issue(OP_DIV,   32'hFFFF_FFF9, 32'h2, "DIV -7/2");
        wait_free();
        issue(OP_DIVU,  32'd100, 32'd7, "DIVU 100/7");
        while (cyc + 1 < free_edge - 1) idle(1);
        issue(OP_MTHI,  32'hAAAA_5555, 32'h0, "MTHI on busy-fall edge");
        issue(OP_MTLO,  32'h0000_0042, 32'h0, "MTLO after busy");
        issue(OP_DIVU,  32'd5, 32'd0, "DIVU 5/0");
        issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "DIV minneg/-1");
        idle(3);
        issue(OP_MTLO,  32'h1, 32'h0, "MTLO during divide");
        wait_free();
        issue(OP_DIV,   32'd1000, 32'd3, "DIV to abort");
        idle(9);
        async_reset("reset mid-divide");
        issue(OP_MTHI,  32'h5, 32'h0, "MTHI after reset");

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) != 0) wait_free();
            op_r = 3'($urandom_range(0, 7));
            rs_r = $urandom();
            rt_r = $urandom();
            case ($urandom_range(0, 7))
                0: rt_r = 32'd0;
                1: rt_r = 32'hFFFF_FFFF;
                2: rs_r = 32'h8000_0000;
                3: rt_r = 32'($urandom_range(1, 20));
                default: ;
            endcase
            issue(op_r, rs_r, rt_r, $sformatf("rand op=%0d rs=%h rt=%h", op_r, rs_r, rt_r));
        end

        wait_free();
        idle(2);
        for (int k = 0; k < 100 && sb.size() != 0; k++) idle(1);
        idle(1);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL wait expired: %0d expectation(s) never checked", sb.size());
            foreach (sb[i])
                $display("FAIL   pending %s due=%0d", sb[i].name, sb[i].due);
        end else begin
            $display("[TB] ok   scoreboard drained cyc=%0d", cyc);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mips_cpu_hilo_unit.md
MIPS_CPU_HILO_UNIT -- requirements
Module: mips_cpu_hilo_unit

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of HI, LO and operands (even, >= 8).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 op_valid  input  1  request strobe; accepted on an edge where op_valid=1 and busy=0.
REQ-005 op  input  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO; other codes are no-ops.
REQ-006 rs_val  input  WIDTH  first operand (dividend, multiplicand, MTHI/MTLO source).
REQ-007 rt_val  input  WIDTH  second operand (divisor, multiplier).
REQ-008 busy  output  1  divide in progress; requests ignored while high.
REQ-009 hi_out  output  WIDTH  current HI register value.
REQ-010 lo_out  output  WIDTH  current LO register value.
REQ-011 div_by_zero  output  1  one-cycle pulse: divide accepted with rt_val=0.

Function
REQ-012 States IDLE and DIVIDE; busy=1 exactly when the state is DIVIDE.
REQ-013 MTHI/MTLO: HI (LO) <= rs_val at the accepting edge; the other register is unchanged; visible one cycle later.
REQ-014 MULTU: {HI,LO} <= unsigned rs_val*rt_val at the accepting edge; 2*WIDTH-bit product, no truncation.
REQ-015 MULT: same as MULTU with two's-complement operands and signed 2*WIDTH-bit product.
REQ-016 DIV/DIVU with rt_val!=0: accepting edge enters DIVIDE and latches operands; busy high for exactly WIDTH cycles; the edge ending cycle WIDTH writes LO=quotient, HI=remainder and returns to IDLE.
REQ-017 HI/LO hold their previous values throughout DIVIDE until the final write.
REQ-018 DIV signed: quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-019 DIV with most-negative/-1: LO=most-negative value (wraps), HI=0; no flag.
REQ-020 DIV/DIVU with rt_val=0: no DIVIDE entry; HI<=rs_val, LO<=all ones at the accepting edge; div_by_zero=1 for the following cycle.
REQ-021 A request presented on the edge busy falls is ignored; the next edge with busy=0 accepts.
REQ-022 Undefined op codes accepted without any state change.

Reset
REQ-023 While reset=1: hi_out=0, lo_out=0, busy=0, div_by_zero=0, state IDLE, asynchronously.
REQ-024 Reset during DIVIDE aborts the divide; no partial result is written; first post-reset edge accepts requests.

Configuration
REQ-025 Macro MIPS_CPU_HILO_DIV_EN: defined -> divider built, DIV/DIVU behave per REQ-016..REQ-020.
REQ-026 Undefined -> divider omitted, DIV/DIVU treated as undefined ops (REQ-022), busy tied 0, div_by_zero tied 0.

Structure
REQ-027 Package mips_cpu_hilo_pkg holds the op enum, the state enum and the WIDTH default constant.
REQ-028 Sub-module mips_cpu_hilo_divider: iterative restoring unsigned divider, one quotient bit per cycle, start/done handshake; sign handling stays in the parent.

Verification (WIDTH=32)
REQ-029 MTHI 0xDEADBEEF then MTLO 0x12345678 -> hi_out=0xDEADBEEF, lo_out=0x12345678, busy never asserted.
REQ-030 MULT 0xFFFFFFFF*0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-031 DIV -7/2 -> busy high 32 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2.
REQ-032 DIVU 5/0 -> next cycle HI=5, LO=0xFFFFFFFF, div_by_zero pulses once, busy stays 0.
REQ-033 MTLO 0x1 asserted during DIVIDE -> ignored; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-034 Reset asserted at cycle 10 of a divide -> HI=LO=0, busy=0 immediately; MTHI 0x5 right after release -> HI=0x5.
